// File: rtl/i2c_scl_gen_stretch.sv
// -----------------------------------------------------------------------------
// i2c_scl_gen_stretch
//
// I2C master bus-clock generator. One bit time is four quarters ("phases") of
// div_cur clk cycles each:
//   phase 0 : SCL driven low,  data_clk=0  (data may change)
//   phase 1 : SCL driven low,  data_clk=1
//   phase 2 : SCL released,    data_clk=1, switch_range=1 (SCL-high sample)
//   phase 3 : SCL released,    data_clk=0
// During phase 2 a target may hold SCL low (clock stretching). The pad
// readback is synchronised and the quarter counter is frozen while SCL reads
// low, bounded by a programmable timeout that raises a sticky error.
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   enable         run request from the bit FSM (sampled at bit boundaries)
//   div            quarter period in clk cycles (0 behaves as 1)
//   div_load       pulse: capture div into the pending divider register
//   stretch_en     allow the target to stretch the SCL-high phase
//   timeout        stretch limit in clk cycles (0 selects DEF_TIMEOUT)
//   err_clr        clears timeout_err
//   scl_in         asynchronous SCL pad readback
//   scl_oe         1 = pull SCL low, 0 = release
//   data_clk       data-phase clock (high in phases 1 and 2)
//   switch_range   high during phase 2
//   phase          current quarter 0..3
//   cycle_done     one-cycle pulse on the last cycle of phase 3
//   stretch_active counter currently held by a target stretch
//   timeout_err    sticky stretch-timeout flag
//   busy           generator is running
// -----------------------------------------------------------------------------
module i2c_scl_gen_stretch #(
    parameter int DIV_W       = 18,
    parameter int DEF_DIV     = 35000,
    parameter int SYNC_STAGES = 2,
    parameter int TO_W        = 20,
    parameter int DEF_TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic             div_load,
    input  logic             stretch_en,
    input  logic [TO_W-1:0]  timeout,
    input  logic             err_clr,
    input  logic             scl_in,
    output logic             scl_oe,
    output logic             data_clk,
    output logic             switch_range,
    output logic [1:0]       phase,
    output logic             cycle_done,
    output logic             stretch_active,
    output logic             timeout_err,
    output logic             busy
);

    localparam logic [DIV_W-1:0] DEF_DIV_V  = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] SYNC_CMP   = DIV_W'(SYNC_STAGES);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [TO_W-1:0]  DEF_TO_V   = TO_W'(DEF_TIMEOUT);
    localparam logic [TO_W:0]    TO_INC_ONE = (TO_W+1)'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       phase_reg, phase_next;
    logic [DIV_W-1:0] div_cur_reg, div_cur_next;
    logic [DIV_W-1:0] div_pend_reg, div_pend_next;
    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
    logic             to_hit_reg, to_hit_next;
    logic             stretch_reg, stretch_next;
    logic             err_reg, err_next;

    logic             scl_sync;
    logic             run;
    logic             last_cnt;
    logic             hold;
    logic             to_now;
    logic [DIV_W-1:0] div_pend_eff;
    logic [TO_W-1:0]  to_limit;
    logic [TO_W:0]    to_inc;

    // ---------------------------------------------------------------------
    // SCL readback synchroniser; resets to 1 (idle bus level) so a freshly
    // reset block never sees a phantom stretch.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic q_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) q_reg <= 1'b1;
                    else     q_reg <= scl_in;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) q_reg <= 1'b1;
                    else     q_reg <= g_sync[gi-1].q_reg;
                end
            end
        end
    endgenerate

    assign scl_sync = g_sync[SYNC_STAGES-1].q_reg;

    // ---------------------------------------------------------------------
    // Next-state / datapath
    // ---------------------------------------------------------------------
    assign run          = (state_reg == RUN);
    assign last_cnt     = (cnt_reg == div_cur_reg - DIV_ONE);
    assign div_pend_eff = (div_pend_reg == '0) ? DIV_ONE : div_pend_reg;
    assign to_limit     = (timeout == '0) ? DEF_TO_V : timeout;
    assign to_inc       = {1'b0, to_cnt_reg} + TO_INC_ONE;

    // The blanking window (cnt >= SYNC_STAGES) hides the synchroniser's
    // stale "low" from phase 1, when we were still pulling SCL down.
    assign hold   = run && (phase_reg == 2'd2) && stretch_en &&
                    (cnt_reg >= SYNC_CMP) && !scl_sync && !to_hit_reg;
    assign to_now = hold && (to_inc >= {1'b0, to_limit});

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        phase_next    = phase_reg;
        div_cur_next  = div_cur_reg;
        div_pend_next = div_load ? div : div_pend_reg;
        to_cnt_next   = to_cnt_reg;
        to_hit_next   = to_hit_reg;
        stretch_next  = 1'b0;
        // A timeout in the same cycle as err_clr keeps the flag set.
        err_next      = (err_reg && !err_clr) || to_now;

        case (state_reg)
            IDLE: begin
                cnt_next     = '0;
                phase_next   = 2'd0;
                div_cur_next = div_pend_eff;
                to_cnt_next  = '0;
                to_hit_next  = 1'b0;
                if (enable) state_next = RUN;
            end

            RUN: begin
                if (hold) begin
                    to_cnt_next = to_inc[TO_W-1:0];
                    if (to_now) to_hit_next  = 1'b1;
                    else        stretch_next = 1'b1;
                end else if (last_cnt) begin
                    cnt_next    = '0;
                    phase_next  = phase_reg + 2'd1;
                    to_cnt_next = '0;
                    to_hit_next = 1'b0;
                    if (phase_reg == 2'd3) begin
                        // Bit boundary: only place the period may change and
                        // the only place we may stop, so SCL ends released.
                        div_cur_next = div_pend_eff;
                        if (!enable) state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + DIV_ONE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            phase_reg    <= 2'd0;
            div_cur_reg  <= DEF_DIV_V;
            div_pend_reg <= DEF_DIV_V;
            to_cnt_reg   <= '0;
            to_hit_reg   <= 1'b0;
            stretch_reg  <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            phase_reg    <= phase_next;
            div_cur_reg  <= div_cur_next;
            div_pend_reg <= div_pend_next;
            to_cnt_reg   <= to_cnt_next;
            to_hit_reg   <= to_hit_next;
            stretch_reg  <= stretch_next;
            err_reg      <= err_next;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: decoded from registers only.
    // ---------------------------------------------------------------------
    assign busy           = run;
    assign phase          = phase_reg;
    assign scl_oe         = run && (phase_reg == 2'd0 || phase_reg == 2'd1);
    assign data_clk       = run && (phase_reg == 2'd1 || phase_reg == 2'd2);
    assign switch_range   = run && (phase_reg == 2'd2);
    assign cycle_done     = run && (phase_reg == 2'd3) && last_cnt;
    assign stretch_active = stretch_reg;
    assign timeout_err    = err_reg;

endmodule

// File: tb/tb_i2c_scl_gen_stretch.sv
// -----------------------------------------------------------------------------
// tb_i2c_scl_gen_stretch
//
// Inputs are driven on the falling edge; the expected outputs for the cycle
// that follows are pushed onto a scoreboard queue at the same moment and
// popped/compared 2 ns after the next rising edge. Cycle numbers (c) count
// from the first RUN cycle of each bit.
// -----------------------------------------------------------------------------
module tb_i2c_scl_gen_stretch;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [17:0] div;
    logic        div_load;
    logic        stretch_en;
    logic [19:0] timeout;
    logic        err_clr;
    logic        scl_in;
    logic        scl_oe;
    logic        data_clk;
    logic        switch_range;
    logic [1:0]  phase;
    logic        cycle_done;
    logic        stretch_active;
    logic        timeout_err;
    logic        busy;

    i2c_scl_gen_stretch dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .div            (div),
        .div_load       (div_load),
        .stretch_en     (stretch_en),
        .timeout        (timeout),
        .err_clr        (err_clr),
        .scl_in         (scl_in),
        .scl_oe         (scl_oe),
        .data_clk       (data_clk),
        .switch_range   (switch_range),
        .phase          (phase),
        .cycle_done     (cycle_done),
        .stretch_active (stretch_active),
        .timeout_err    (timeout_err),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       chk;
        logic [7:0] tid;
        logic [7:0] cyc;
        logic       busy;
        logic       oe;
        logic       dclk;
        logic       sr;
        logic       cd;
        logic [1:0] ph;
        logic       sa;
        logic       te;
    } exp_t;

    typedef struct packed {
        logic enable;
        logic scl_in;
        exp_t e;
    } vec_t;

    exp_t exp_q[$];
    exp_t e_mon;
    vec_t nom_tab [16];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic exp_t mk(input int tid, input int c, input logic b,
                                input logic oe, input logic dclk, input logic sr,
                                input logic cd, input logic [1:0] ph,
                                input logic sa, input logic te);
        exp_t e;
        e.chk  = 1'b1;
        e.tid  = 8'(tid);
        e.cyc  = 8'(c);
        e.busy = b;
        e.oe   = oe;
        e.dclk = dclk;
        e.sr   = sr;
        e.cd   = cd;
        e.ph   = ph;
        e.sa   = sa;
        e.te   = te;
        return e;
    endfunction

    // Unstretched bit with quarter period d, cycle c of 4*d.
    function automatic exp_t nom(input int tid, input int c, input int d,
                                 input logic sa, input logic te);
        int p;
        p = c / d;
        return mk(tid, c, 1'b1, p < 2, (p == 1) || (p == 2), p == 2,
                  c == 4 * d - 1, 2'(p), sa, te);
    endfunction

    function automatic exp_t idle(input int tid, input int c);
        return mk(tid, c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    endfunction

    task automatic check(input exp_t e);
        logic [8:0] got;
        logic [8:0] want;
        got  = {busy, scl_oe, data_clk, switch_range, cycle_done, phase,
                stretch_active, timeout_err};
        want = {e.busy, e.oe, e.dclk, e.sr, e.cd, e.ph, e.sa, e.te};
        n_checks++;
        if (got === want) begin
            n_pass++;
            $display("ok   t%0d c%0d {busy,oe,dclk,sr,cd,ph,sa,te}=%b",
                     e.tid, e.cyc, got);
        end else begin
            $display("FAIL t%0d c%0d {busy,oe,dclk,sr,cd,ph,sa,te} got %b want %b",
                     e.tid, e.cyc, got, want);
        end
    endtask

    // Scoreboard consumer: one entry per cycle, checked after the edge.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            if (e_mon.chk) check(e_mon);
        end
    end

    // Inputs are already set by the caller; push what the next cycle must show.
    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int eff;
        logic sa;
        logic te;
        exp_t e;

        rst = 1'b1; enable = 1'b0; div = '0; div_load = 1'b0;
        stretch_en = 1'b1; timeout = '0; err_clr = 1'b0; scl_in = 1'b1;

        for (int c = 0; c < 16; c++) begin
            nom_tab[c].enable = 1'b1;
            nom_tab[c].scl_in = 1'b1;
            nom_tab[c].e      = nom(1, c, 4, 1'b0, 1'b0);
        end

        @(negedge clk);

        // t0: reset state, load div=4 while idle
        step(idle(0, 0));
        step(idle(0, 1));
        rst = 1'b0; div = 18'd4; div_load = 1'b1;
        step(idle(0, 2));
        div_load = 1'b0;
        step(idle(0, 3));

        // t1: nominal 16-cycle bit from the vector table
        for (int c = 0; c < 16; c++) begin
            enable = nom_tab[c].enable;
            scl_in = nom_tab[c].scl_in;
            step(nom_tab[c].e);
        end

        // t2: 10-cycle stretch in phase 2, back-to-back with previous bit
        for (int c = 0; c < 26; c++) begin
            scl_in = (c >= 9 && c <= 18) ? 1'b0 : 1'b1;
            eff = (c <= 10) ? c : ((c <= 20) ? 10 : c - 10);
            sa  = (c >= 11 && c <= 20);
            e = nom(2, eff, 4, sa, 1'b0);
            e.cyc = 8'(c);
            step(e);
        end

        // t3: stuck-low SCL, timeout=5
        for (int c = 0; c < 21; c++) begin
            timeout = 20'd5;
            scl_in = (c >= 9 && c <= 16) ? 1'b0 : 1'b1;
            eff = (c <= 10) ? c : ((c <= 15) ? 10 : c - 5);
            sa  = (c >= 11 && c <= 14);
            te  = (c >= 15);
            e = nom(3, eff, 4, sa, te);
            e.cyc = 8'(c);
            step(e);
        end

        // t4: normal period after timeout; err_clr clears the sticky flag
        for (int c = 0; c < 16; c++) begin
            timeout = '0;
            err_clr = (c == 5);
            step(nom(4, c, 4, 1'b0, c < 5));
        end
        err_clr = 1'b0;

        // t5: div=2 loaded mid-bit; current bit keeps 16 cycles
        for (int c = 0; c < 16; c++) begin
            div = 18'd2;
            div_load = (c == 5);
            step(nom(5, c, 4, 1'b0, 1'b0));
        end
        div_load = 1'b0;

        // t6: next bit at 8 cycles; enable dropped in phase 1, then idle
        for (int c = 0; c < 8; c++) begin
            enable = (c < 3);
            step(nom(6, c, 2, 1'b0, 1'b0));
        end
        for (int c = 8; c < 11; c++) step(idle(6, c));

        // t7: div=0 gives a 4-cycle bit; stretch_en=0 with scl_in low
        div = '0; div_load = 1'b1;
        step(idle(7, 99));
        div_load = 1'b0; stretch_en = 1'b0; scl_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            enable = 1'b1;
            div = 18'd4;
            div_load = (c == 1);
            step(nom(7, c, 1, 1'b0, 1'b0));
        end
        div_load = 1'b0;

        // t8: div=4 with stretch disabled, SCL held low: no hold
        for (int c = 0; c < 16; c++) step(nom(8, c, 4, 1'b0, 1'b0));

        // t9: reset in the middle of a stretch
        stretch_en = 1'b1;
        for (int c = 0; c < 11; c++) step(nom(9, c, 4, 1'b0, 1'b0));
        e = nom(9, 10, 4, 1'b1, 1'b0);
        e.cyc = 8'd11;
        step(e);
        rst = 1'b1; enable = 1'b0;
        step(idle(9, 12));
        step(idle(9, 13));
        rst = 1'b0; scl_in = 1'b1;
        step(idle(9, 14));
        step(idle(9, 15));

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
